alu_mul_seq: RTL and testbench

ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

---
 rtl/alu_mul_seq.sv | 130 +++++++++++++
 tb/tb_alu_mul_seq.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier that borrows the CPU's registered ALU: dw iterations of ISSUE/CAPTURE, done 2*dw+1 RDY edges after start.
// RDY=0 freezes every register and holds the ALU drive; start is ignored unless idle, and reset aborts with the ALU handed back at once.
module alu_mul_seq #(
    parameter int dw = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            RDY,
    input  logic            start,
    input  logic [dw-1:0]   a,
    input  logic [dw-1:0]   b,
    output logic            busy,
    output logic            done,
    output logic [2*dw-1:0] product,
    input  logic [3:0]      cpu_op,
    input  logic            cpu_right,
    input  logic [dw-1:0]   cpu_ai,
    input  logic [dw-1:0]   cpu_bi,
    input  logic            cpu_ci,
    output logic [3:0]      alu_op,
    output logic            alu_right,
    output logic [dw-1:0]   alu_ai,
    output logic [dw-1:0]   alu_bi,
    output logic            alu_ci,
    input  logic [dw-1:0]   alu_out,
    input  logic            alu_co
);

    localparam int CW = (dw > 1) ? $clog2(dw) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [dw-1:0]     mcand_q, mcand_d;
    logic [dw-1:0]     mlr_q, mlr_d;
    logic [dw-1:0]     acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*dw-1:0]   product_q, product_d;
    logic [3:0]        seq_op;
    logic              last_bit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            mlr_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else if (RDY) begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mlr_q     <= mlr_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    // Add the multiplicand only when the current multiplier LSB is set; otherwise pass the accumulator through.
    assign seq_op   = mlr_q[0] ? 4'b0011 : 4'b1111;
    assign last_bit = (cnt_q == CW'(dw - 1));

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mlr_d     = mlr_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d = a;
                    mlr_d   = b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                acc_d = {alu_co, alu_out[dw-1:1]};
                mlr_d = {alu_out[0], mlr_q[dw-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (last_bit) begin
                    // Load the product from the final shift so it is visible together with done.
                    product_d = {alu_co, alu_out[dw-1:1], alu_out[0], mlr_q[dw-1:1]};
                    cnt_d     = cnt_q;
                    state_d   = S_DONE;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy    = (state_q == S_ISSUE) || (state_q == S_CAPTURE);
    assign done    = (state_q == S_DONE);
    assign product = product_q;

    always_comb begin
        alu_op    = cpu_op;
        alu_right = cpu_right;
        alu_ai    = cpu_ai;
        alu_bi    = cpu_bi;
        alu_ci    = cpu_ci;
        if (busy) begin
            alu_op    = seq_op;
            alu_right = 1'b0;
            alu_ai    = acc_q;
            alu_bi    = mcand_q;
            alu_ci    = 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: registered-ALU stand-in, transaction-level multiply model, per-cycle compare, directed and random stimulus.
module tb_alu_mul_seq;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            reset, RDY, start;
    logic [DW-1:0]   a, b;
    logic            busy, done;
    logic [2*DW-1:0] product;
    logic [3:0]      cpu_op, alu_op;
    logic            cpu_right, alu_right, cpu_ci, alu_ci;
    logic [DW-1:0]   cpu_ai, cpu_bi, alu_ai, alu_bi;
    logic [DW-1:0]   alu_out;
    logic            alu_co;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_mul_seq #(.dw(DW)) dut (
        .clk(clk), .reset(reset), .RDY(RDY), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .product(product),
        .cpu_op(cpu_op), .cpu_right(cpu_right), .cpu_ai(cpu_ai), .cpu_bi(cpu_bi), .cpu_ci(cpu_ci),
        .alu_op(alu_op), .alu_right(alu_right), .alu_ai(alu_ai), .alu_bi(alu_bi), .alu_ci(alu_ci),
        .alu_out(alu_out), .alu_co(alu_co)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Registered ALU stand-in: 0011 adds with carry out, 1111 passes AI.
    always @(posedge clk) begin
        if (RDY) begin
            case (alu_op)
                4'b0011: {alu_co, alu_out} <= {1'b0, alu_ai} + {1'b0, alu_bi} + {{DW{1'b0}}, alu_ci};
                4'b1111: begin alu_out <= alu_ai; alu_co <= 1'b0; end
                default: begin alu_out <= alu_ai ^ alu_bi; alu_co <= alu_ci; end
            endcase
        end
    end

    // Transaction model: an accepted multiply occupies 2*DW RDY edges, then done for one RDY edge.
    int          m_left = 0;
    bit          m_done = 1'b0;
    logic [63:0] m_prod = '0;
    logic [63:0] m_a = '0;
    logic [63:0] m_b = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_left = 0;
            m_done = 1'b0;
            m_prod = '0;
        end else if (RDY) begin
            if (m_done) begin
                m_done = 1'b0;
            end else if (m_left > 0) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_done = 1'b1;
                    m_prod = m_a * m_b;
                end
            end else if (start) begin
                m_a    = 64'(a);
                m_b    = 64'(b);
                m_left = 2 * DW;
            end
        end
    end

    always @(posedge clk) begin
        int          step;
        logic [63:0] acc_e;
        logic [3:0]  op_e;
        #1;
        chk("busy", 64'(busy), 64'(m_left > 0));
        chk("done", 64'(done), 64'(m_done));
        chk("product", 64'(product), m_prod);
        if (m_left > 0) begin
            step  = (2 * DW - m_left) / 2;
            acc_e = (m_a * (m_b & ((64'd1 << step) - 64'd1))) >> step;
            op_e  = m_b[step] ? 4'b0011 : 4'b1111;
            chk("seq_op", 64'(alu_op), 64'(op_e));
            chk("seq_ai", 64'(alu_ai), acc_e);
            chk("seq_bi", 64'(alu_bi), m_a);
            chk("seq_ci_right", 64'({alu_ci, alu_right}), 64'd0);
        end else begin
            chk("pass_op", 64'(alu_op), 64'(cpu_op));
            chk("pass_ai", 64'(alu_ai), 64'(cpu_ai));
            chk("pass_bi", 64'(alu_bi), 64'(cpu_bi));
            chk("pass_ci_right", 64'({alu_ci, alu_right}), 64'({cpu_ci, cpu_right}));
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #3;
            cpu_op    = 4'($urandom);
            cpu_right = 1'($urandom);
            cpu_ai    = DW'($urandom);
            cpu_bi    = DW'($urandom);
            cpu_ci    = 1'($urandom);
        end
    end

    function automatic logic [DW-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            default: return DW'($urandom);
        endcase
    endfunction

    // Runs one multiply from the cycle before edge 0; lat is the cycle index (edge 0 ends cycle 0) in which done is seen.
    task automatic run_op(input logic [DW-1:0] ia, input logic [DW-1:0] ib, input int gap, input int restart,
                          output int lat, output logic [2*DW-1:0] prod, output int addc, output int busyc);
        bit got;
        @(negedge clk);
        a = ia; b = ib; start = 1'b1; RDY = 1'b1;
        @(negedge clk);
        start = 1'b0; a = DW'($urandom); b = DW'($urandom);
        lat = 1; addc = 0; busyc = 0; got = 1'b0; prod = '0;
        while (!got && lat < 200) begin
            if (busy) busyc++;
            if (busy && alu_op == 4'b0011) addc++;
            if (done) begin
                got  = 1'b1;
                prod = product;
            end else begin
                RDY = !(gap >= 0 && lat >= gap && lat < gap + 5);
                if (lat == restart) begin
                    start = 1'b1; a = 16'h5A5A; b = 16'h7777;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                lat++;
            end
        end
        RDY = 1'b1; start = 1'b0;
        chk("op_timeout", 64'(got), 64'd1);
    endtask

    initial begin
        int              lat, addc, busyc, seen;
        logic [2*DW-1:0] prod;
        reset = 1'b1; RDY = 1'b0; start = 1'b1; a = '1; b = '1;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_product", 64'(product), 64'd0);
        reset = 1'b0; start = 1'b0; RDY = 1'b1;

        run_op(16'hFFFF, 16'hFFFF, -1, -1, lat, prod, addc, busyc);
        chk("ffff_latency", 64'(lat), 64'd33);
        chk("ffff_product", 64'(prod), 64'hFFFE0001);
        chk("ffff_busy_cycles", 64'(busyc), 64'd32);
        @(negedge clk);
        chk("ffff_done_one_cycle", 64'(done), 64'd0);

        run_op(16'h1234, 16'h0010, -1, -1, lat, prod, addc, busyc);
        chk("b10_product", 64'(prod), 64'h00012340);
        chk("b10_add_cycles", 64'(addc), 64'd2);

        run_op(16'h00FF, 16'h0000, -1, -1, lat, prod, addc, busyc);
        chk("zero_product", 64'(prod), 64'd0);
        chk("zero_add_cycles", 64'(addc), 64'd0);

        run_op(16'h0003, 16'h0005, 10, -1, lat, prod, addc, busyc);
        chk("stall_latency", 64'(lat), 64'd38);
        chk("stall_product", 64'(prod), 64'h0000000F);

        run_op(16'h00AB, 16'h0CD1, -1, 5, lat, prod, addc, busyc);
        chk("restart_product", 64'(prod), 64'h00088F9B);
        chk("restart_latency", 64'(lat), 64'd33);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        chk("restart_not_queued", 64'(seen), 64'd0);

        @(negedge clk);
        a = 16'hBEEF; b = 16'h1357; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("abort_was_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_product", 64'(product), 64'd0);
        chk("abort_alu_op", 64'(alu_op), 64'(cpu_op));
        chk("abort_alu_ai", 64'(alu_ai), 64'(cpu_ai));
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("abort_no_done", 64'(seen), 64'd0);

        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 99) < 1);
            RDY   = ($urandom_range(0, 99) < 85);
            start = ($urandom_range(0, 99) < 20);
            a     = pick();
            b     = pick();
        end
        @(negedge clk);
        reset = 1'b0; start = 1'b0; RDY = 1'b1;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
